siso_serializer_ctrl: RTL and testbench
=======================================

// Module: siso_serializer_ctrl
// PURPOSE
//  Controller for a DEPTH-stage serial-in/serial-out D-flip-flop chain. Accepts parallel words over
//  a valid/ready handshake, serializes each word MSB-first into the chain and shifts it through.
//  Runs a valid/last tag chain alongside the data and flushes the pipe at the end of a burst.
//  Sits between a parallel producer and a serial consumer; owns sequencing of the shift chain.
// PARAMETERS
//  WIDTH  8  bits per parallel word (>=2)
//  DEPTH  4  number of SISO chain stages = serial pipeline latency (>=1)
// PORTS
//  clk        in   1      single clock; all state changes on posedge
//  rst_n      in   1      synchronous, active-high reset (1 = reset)
//  abort      in   1      synchronous cancel of current burst; lower priority than rst_n
//  in_valid   in   1      producer has a word on in_data
//  in_data    in   WIDTH  parallel word, captured on handshake
//  in_ready   out  1      controller can accept a word this cycle
//  sout       out  1      serial data = last chain stage
//  sout_valid out  1      sout carries a real data bit
//  sout_last  out  1      sout is bit 0 (LSB) of a word
//  busy       out  1      FSM not in IDLE
//  done       out  1      1-cycle pulse: final bit of a burst is on sout
// BEHAVIOUR
//  Reset (rst_n=1 at posedge): FSM->IDLE; shift word, bit and flush counters, all chain data, valid
//   and last stages cleared to 0. All outputs 0 next cycle, except in_ready=1 (IDLE).
//  Handshake: word accepted on posedge with in_valid&in_ready. in_data is don't-care otherwise.
//  in_ready = (state==IDLE) | (state==SHIFT & bitcnt==WIDTH-1). Always 0 in FLUSH.
//  FSM states:
//   IDLE : chain input 0, valid-in 0. Accept -> load shreg, bitcnt=0, -> SHIFT.
//   SHIFT: chain input = shreg[WIDTH-1], valid-in 1, last-in = (bitcnt==WIDTH-1).
//          Each edge: shreg<<=1, bitcnt++.
//          At bitcnt==WIDTH-1: accept -> reload, bitcnt=0, stay SHIFT (gapless back-to-back);
//          else -> FLUSH, flushcnt=1.
//   FLUSH: chain input 0, valid-in 0, last-in 0. Lasts exactly DEPTH cycles (flushcnt 1..DEPTH).
//          done=1 in cycle DEPTH. -> IDLE at the end of that cycle.
//  Chain: data/valid/last stages shift one position per edge in every state.
//   sout, sout_valid and sout_last = stage DEPTH.
//  Latency: bit k of an accepted word is on sout in the cycle after edge (A+k+DEPTH),
//   where A = accepting edge. First sout_valid is DEPTH edges after accept.
//   A burst of N words gives N*WIDTH contiguous sout_valid cycles.
//  done = (state==FLUSH) & (flushcnt==DEPTH); this coincides with sout_valid=sout_last=1.
//   No done for words inside a back-to-back burst.
//  busy = 1 from cycle after accept until IDLE is re-entered. A single word gives WIDTH+DEPTH busy cycles.
//  abort=1 at posedge (any state):
//   FSM->IDLE, shreg and counters cleared, all valid/last stages cleared; data stages may retain bits.
//   No word is accepted on that edge (in_ready ignored). done is not pulsed.
//  rst_n overrides abort and in_valid on the same edge. Reset mid-word: word lost, no done.
//  Counters: bitcnt is $clog2(WIDTH) bits, flushcnt is $clog2(DEPTH+1) bits, no wrap beyond terminal values.
// TESTING (WIDTH=8, DEPTH=4)
//  1. Reset, then 1 word 0xA5 accepted at edge A
//     -> sout 1,0,1,0,0,1,0,1 with sout_valid=1 on cycles after edges A+4..A+11;
//        sout_last and done only in the 8th; busy for 12 cycles; in_ready=0 in FLUSH.
//  2. Back-to-back 0xA5 then 0x3C (second accepted at bitcnt=7)
//     -> 16 contiguous valid bits 10100101_00111100; sout_last in bits 8 and 16; single done at bit 16.
//  3. in_valid held high with 0xFF during FLUSH of a 0x00 word
//     -> in_ready=0 for 4 FLUSH cycles; 0xFF accepted on first IDLE cycle; 8 ones emitted.
//  4. rst_n=1 while bit 3 of 0x5A is in the chain
//     -> next cycle sout=sout_valid=busy=done=0, in_ready=1; a new 0x81 word then serializes cleanly.
//  5. abort=1 while in SHIFT with bitcnt=5 and in_valid=1
//     -> next cycle IDLE, sout_valid=0, no done, word not accepted; re-presented word fully serialized.
//  6. Word 0x01 then idle
//     -> sout_valid for exactly 8 cycles; only the last has sout=1, with sout_last=done=1.

Source files
------------

// File: rtl/siso_serializer_ctrl_if.sv
// Parallel word handshake between a producer and the SISO serializer controller.
// The producer drives valid/data; the controller returns ready.
interface siso_serializer_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/siso_serializer_ctrl.sv
// Serializes parallel words MSB-first into a DEPTH-stage SISO flip-flop chain.
// A valid/last tag chain runs alongside the data, and the pipe is flushed at the end of each burst.
module siso_serializer_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  abort,
  siso_serializer_ctrl_if.slave in_if,
  output logic                  sout,
  output logic                  sout_valid,
  output logic                  sout_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int FW = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1;
  localparam logic [CW-1:0] BIT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] BIT_ONE    = CW'(1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(WIDTH - 1);
  localparam logic [FW-1:0] FLUSH_ZERO = {FW{1'b0}};
  localparam logic [FW-1:0] FLUSH_ONE  = FW'(1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [CW-1:0]    bitcnt_r;
  logic [FW-1:0]    flushcnt_r;
  logic             in_ready_r;
  logic             busy_r;
  logic             done_r;
  logic [DEPTH-1:0] data_r;
  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] last_r;

  logic accept_s;
  logic chain_d_s;
  logic chain_v_s;
  logic chain_l_s;

  assign accept_s = in_if.in_valid & in_ready_r;

  // Chain input: only SHIFT feeds real bits; IDLE and FLUSH push bubbles.
  always_comb begin
    chain_d_s = 1'b0;
    chain_v_s = 1'b0;
    chain_l_s = 1'b0;
    if (state_r == ST_SHIFT) begin
      chain_d_s = shreg_r[WIDTH-1];
      chain_v_s = 1'b1;
      chain_l_s = (bitcnt_r == BIT_LAST);
    end else begin
      chain_d_s = 1'b0;
      chain_v_s = 1'b0;
      chain_l_s = 1'b0;
    end
  end

  // Sequencing FSM; in_ready/busy/done are registered from the next-state decision.
  always_ff @(posedge clk) begin
    if (rst_n || abort) begin
      state_r    <= ST_IDLE;
      shreg_r    <= {WIDTH{1'b0}};
      bitcnt_r   <= BIT_ZERO;
      flushcnt_r <= FLUSH_ZERO;
      in_ready_r <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (accept_s) begin
            state_r    <= ST_SHIFT;
            shreg_r    <= in_if.in_data;
            bitcnt_r   <= BIT_ZERO;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
          end
        end
        ST_SHIFT: begin
          busy_r <= 1'b1;
          if (bitcnt_r == BIT_LAST) begin
            if (accept_s) begin
              shreg_r    <= in_if.in_data;
              bitcnt_r   <= BIT_ZERO;
              in_ready_r <= 1'b0;
              done_r     <= 1'b0;
            end else begin
              // Burst ends: drain the chain before returning to IDLE.
              state_r    <= ST_FLUSH;
              shreg_r    <= {shreg_r[WIDTH-2:0], 1'b0};
              bitcnt_r   <= BIT_ZERO;
              flushcnt_r <= FLUSH_ONE;
              in_ready_r <= 1'b0;
              done_r     <= (FLUSH_ONE == FLUSH_LAST);
            end
          end else begin
            shreg_r    <= {shreg_r[WIDTH-2:0], 1'b0};
            bitcnt_r   <= bitcnt_r + BIT_ONE;
            in_ready_r <= ((bitcnt_r + BIT_ONE) == BIT_LAST);
            done_r     <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (flushcnt_r == FLUSH_LAST) begin
            state_r    <= ST_IDLE;
            flushcnt_r <= FLUSH_ZERO;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
          end else begin
            flushcnt_r <= flushcnt_r + FLUSH_ONE;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            done_r     <= ((flushcnt_r + FLUSH_ONE) == FLUSH_LAST);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          shreg_r    <= {WIDTH{1'b0}};
          bitcnt_r   <= BIT_ZERO;
          flushcnt_r <= FLUSH_ZERO;
          in_ready_r <= 1'b1;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  // SISO data chain plus valid/last tags; abort kills the tags but leaves stale data bits.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      data_r  <= {DEPTH{1'b0}};
      valid_r <= {DEPTH{1'b0}};
      last_r  <= {DEPTH{1'b0}};
    end else begin
      data_r[0] <= chain_d_s;
      for (int i = 1; i < DEPTH; i++) begin
        data_r[i] <= data_r[i-1];
      end
      if (abort) begin
        valid_r <= {DEPTH{1'b0}};
        last_r  <= {DEPTH{1'b0}};
      end else begin
        valid_r[0] <= chain_v_s;
        last_r[0]  <= chain_l_s;
        for (int i = 1; i < DEPTH; i++) begin
          valid_r[i] <= valid_r[i-1];
          last_r[i]  <= last_r[i-1];
        end
      end
    end
  end

  assign in_if.in_ready = in_ready_r;
  assign sout           = data_r[DEPTH-1];
  assign sout_valid     = valid_r[DEPTH-1];
  assign sout_last      = last_r[DEPTH-1];
  assign busy           = busy_r;
  assign done           = done_r;

endmodule

// File: tb/tb_siso_serializer_ctrl.sv
// Bench for siso_serializer_ctrl: directed scenarios plus a randomized run checked against
// a timeline model that schedules each accepted word's bits at their output cycle.
module tb_siso_serializer_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic abort;
  logic sout, sout_valid, sout_last, busy, done;

  siso_serializer_ctrl_if #(.WIDTH(WIDTH)) bus ();

  siso_serializer_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .in_if     (bus.slave),
    .sout      (sout),
    .sout_valid(sout_valid),
    .sout_last (sout_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Timeline model: n counts edges; expected serial bits keyed by the edge after which they show.
  int n = 0;
  bit active = 1'b0;
  int last_acc = 0;
  int idle_from = 0;
  bit exp_bit[int];
  bit exp_last[int];

  logic [31:0] col_bits;
  int n_valid, n_last, n_busy, n_done, n_done_ok, n_runs, n_busy_rdy, first_valid;
  bit prev_valid;

  function automatic bit model_ready(int m);
    return !active || (m >= idle_from) || (m == last_acc + WIDTH - 1);
  endfunction

  function automatic logic [5:0] model_exp(int m);
    bit v, b, l;
    v = exp_bit.exists(m);
    b = 1'b0;
    l = 1'b0;
    if (v) begin
      b = exp_bit[m];
      l = exp_last[m];
    end
    return {b, v, l, active && (m >= last_acc) && (m < idle_from),
            active && (m == idle_from - 1), model_ready(m)};
  endfunction

  task automatic clear_stats();
    col_bits = 32'd0; n_valid = 0; n_last = 0; n_busy = 0; n_done = 0;
    n_done_ok = 0; n_runs = 0; n_busy_rdy = 0; first_valid = -1; prev_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    if (rst_n || abort) begin
      active = 1'b0;
      exp_bit.delete();
      exp_last.delete();
    end else if (bus.in_valid && model_ready(n - 1)) begin
      for (int k = 0; k < WIDTH; k++) begin
        exp_bit[n + k + DEPTH]  = bus.in_data[WIDTH-1-k];
        exp_last[n + k + DEPTH] = (k == WIDTH - 1);
      end
      active = 1'b1;
      last_acc = n;
      idle_from = n + WIDTH + DEPTH;
    end
    @(negedge clk);
    if (sout_valid) begin
      col_bits = {col_bits[30:0], sout};
      n_valid++;
      if (first_valid < 0) first_valid = n;
      if (sout_last) n_last++;
    end
    if (sout_valid && !prev_valid) n_runs++;
    prev_valid = sout_valid;
    if (busy) n_busy++;
    if (busy && bus.in_ready) n_busy_rdy++;
    if (done) n_done++;
    if (done && sout_valid && sout_last) n_done_ok++;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; abort = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'hFF;
    step(); step();
    rst_n = 1'b0; bus.in_valid = 1'b0;
    checks++;
    if ({sout, sout_valid, sout_last, busy, done, bus.in_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_state: got %b expected 000001",
               {sout, sout_valid, sout_last, busy, done, bus.in_ready});
    end
  endtask

  task automatic test_single_word();
    int acc_n;
    clear_stats();
    bus.in_valid = 1'b1; bus.in_data = 8'hA5;
    step();
    acc_n = n;
    bus.in_valid = 1'b0;
    repeat (16) step();
    checks++; if (col_bits[7:0] !== 8'hA5) begin errors++; $display("FAIL single_bits: got %h expected a5", col_bits[7:0]); end
    checks++; if (n_valid != 8) begin errors++; $display("FAIL single_valid_cnt: got %0d expected 8", n_valid); end
    checks++; if (first_valid - acc_n != DEPTH) begin errors++; $display("FAIL single_latency: got %0d expected %0d", first_valid - acc_n, DEPTH); end
    checks++; if (n_busy != 12) begin errors++; $display("FAIL single_busy_cnt: got %0d expected 12", n_busy); end
    checks++; if (n_done != 1 || n_done_ok != 1) begin errors++; $display("FAIL single_done: got %0d/%0d expected 1/1", n_done, n_done_ok); end
    checks++; if (n_last != 1) begin errors++; $display("FAIL single_last_cnt: got %0d expected 1", n_last); end
    checks++; if (n_busy_rdy != 1) begin errors++; $display("FAIL single_ready_while_busy: got %0d expected 1", n_busy_rdy); end
  endtask

  task automatic test_back_to_back();
    int waited;
    clear_stats();
    waited = 0;
    bus.in_valid = 1'b1; bus.in_data = 8'hA5;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && !bus.in_ready; i++) begin
      step();
      waited++;
    end
    checks++; if (waited != 7 || !bus.in_ready) begin errors++; $display("FAIL b2b_ready_wait: got %0d cycles expected 7", waited); end
    bus.in_valid = 1'b1; bus.in_data = 8'h3C;
    step();
    bus.in_valid = 1'b0;
    repeat (20) step();
    checks++; if (col_bits[15:0] !== 16'hA53C) begin errors++; $display("FAIL b2b_bits: got %h expected a53c", col_bits[15:0]); end
    checks++; if (n_valid != 16 || n_runs != 1) begin errors++; $display("FAIL b2b_contiguous: got %0d bits in %0d runs expected 16 in 1", n_valid, n_runs); end
    checks++; if (n_last != 2) begin errors++; $display("FAIL b2b_last_cnt: got %0d expected 2", n_last); end
    checks++; if (n_done != 1 || n_done_ok != 1) begin errors++; $display("FAIL b2b_done: got %0d/%0d expected 1/1", n_done, n_done_ok); end
  endtask

  task automatic test_flush_hold();
    int stalls;
    bit accepted;
    clear_stats();
    stalls = 0; accepted = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h00;
    step();
    bus.in_valid = 1'b0;
    repeat (8) step();
    bus.in_valid = 1'b1; bus.in_data = 8'hFF;
    for (int i = 0; i < 10 && !accepted; i++) begin
      if (bus.in_ready) accepted = 1'b1;
      else stalls++;
      step();
    end
    bus.in_valid = 1'b0;
    repeat (16) step();
    checks++; if (stalls != DEPTH || !accepted) begin errors++; $display("FAIL flush_stalls: got %0d expected %0d", stalls, DEPTH); end
    checks++; if (col_bits[15:0] !== 16'h00FF || n_valid != 16) begin errors++; $display("FAIL flush_bits: got %h/%0d expected 00ff/16", col_bits[15:0], n_valid); end
    checks++; if (n_done != 2) begin errors++; $display("FAIL flush_done_cnt: got %0d expected 2", n_done); end
  endtask

  task automatic test_reset_midword();
    bus.in_valid = 1'b1; bus.in_data = 8'h5A;
    step();
    bus.in_valid = 1'b0;
    repeat (7) step();
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    checks++;
    if ({sout, sout_valid, sout_last, busy, done, bus.in_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL midword_reset: got %b expected 000001",
               {sout, sout_valid, sout_last, busy, done, bus.in_ready});
    end
    clear_stats();
    bus.in_valid = 1'b1; bus.in_data = 8'h81;
    step();
    bus.in_valid = 1'b0;
    repeat (16) step();
    checks++; if (col_bits[7:0] !== 8'h81 || n_valid != 8 || n_done != 1) begin errors++; $display("FAIL post_reset_word: got %h/%0d/%0d expected 81/8/1", col_bits[7:0], n_valid, n_done); end
  endtask

  task automatic test_abort();
    logic [7:0] w;
    w = 8'($urandom);
    bus.in_valid = 1'b1; bus.in_data = 8'hC3;
    step();
    bus.in_valid = 1'b0;
    repeat (5) step();
    abort = 1'b1; bus.in_valid = 1'b1; bus.in_data = w;
    step();
    abort = 1'b0;
    checks++;
    if ({sout_valid, busy, done, bus.in_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL abort_state: got %b expected 0001", {sout_valid, busy, done, bus.in_ready});
    end
    clear_stats();
    step();
    bus.in_valid = 1'b0;
    repeat (16) step();
    checks++; if (col_bits[7:0] !== w || n_valid != 8 || n_done != 1) begin errors++; $display("FAIL abort_represent: got %h/%0d/%0d expected %h/8/1", col_bits[7:0], n_valid, n_done, w); end
  endtask

  task automatic test_word_01();
    clear_stats();
    bus.in_valid = 1'b1; bus.in_data = 8'h01;
    step();
    bus.in_valid = 1'b0;
    repeat (16) step();
    checks++; if (col_bits[7:0] !== 8'h01 || n_valid != 8) begin errors++; $display("FAIL word01_bits: got %h/%0d expected 01/8", col_bits[7:0], n_valid); end
    checks++; if (n_done_ok != 1 || n_done != 1 || n_last != 1) begin errors++; $display("FAIL word01_done_last: got %0d/%0d/%0d expected 1/1/1", n_done_ok, n_done, n_last); end
  endtask

  task automatic test_random();
    logic [5:0] obs, exp;
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(0, 199) == 0);
      abort = ($urandom_range(0, 99) < 3);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data = 8'($urandom);
      step();
      obs = {sout & sout_valid, sout_valid, sout_last, busy, done, bus.in_ready};
      exp = model_exp(n);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random_cycle %0d: got %b expected %b (sout,valid,last,busy,done,ready)", n, obs, exp);
      end
    end
    rst_n = 1'b0; abort = 1'b0; bus.in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; abort = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_flush_hold();
    test_reset_midword();
    test_abort();
    test_word_01();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
